icache_refill_ctrl: RTL and testbench

Miss-handling and refill sequencer for the direct-mapped instruction cache (256 blocks x 512 bit). The block watches fetch lookups and stalls the fetch stage on a miss. It issues a block-aligned read to the memory side, assembles the returned beats into one cache block, and pulses the cache write enable. The fetch stage then resumes on the following hit. It sits between the fetch stage, the instruction cache and the memory/bus interface.

---
 rtl/icache_refill_ctrl.sv | 115 +++++++++++
 tb/tb_icache_refill_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss sequencer: stalls fetch on a miss, reads one block
// from memory beat by beat, then writes the assembled block into the cache.
module icache_refill_ctrl #(
    parameter int ADDR_WIDTH     = 64,
    parameter int BLOCK_WIDTH    = 512,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      arstn,
    input  logic                      i_fetch_req,
    input  logic [ADDR_WIDTH-1:0]     i_fetch_addr,
    input  logic                      i_cache_hit,
    output logic [ADDR_WIDTH-1:0]     o_cache_addr,
    output logic                      o_cache_we,
    output logic [BLOCK_WIDTH-1:0]    o_cache_block,
    output logic                      o_fetch_stall,
    output logic                      o_mem_req,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    input  logic                      i_mem_ack,
    input  logic                      i_mem_rvalid,
    input  logic [MEM_DATA_WIDTH-1:0] i_mem_rdata,
    output logic [CNT_WIDTH-1:0]      o_miss_count
);

    localparam int BEATS  = BLOCK_WIDTH / MEM_DATA_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W  = $clog2(BLOCK_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FILL  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]    miss_addr_q, miss_addr_d;
    logic [BLOCK_WIDTH-1:0]   buf_q, buf_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            miss_addr_q <= '0;
            buf_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            miss_addr_q <= miss_addr_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        miss_addr_d   = miss_addr_q;
        buf_d         = buf_q;
        cnt_d         = cnt_q;
        o_cache_addr  = miss_addr_q;
        o_fetch_stall = 1'b1;
        o_mem_req     = 1'b0;
        o_cache_we    = 1'b0;

        case (state_q)
            IDLE: begin
                // The cache lookup follows the live fetch address until a miss is captured.
                o_cache_addr  = i_fetch_addr;
                o_fetch_stall = i_fetch_req & ~i_cache_hit;
                if (i_fetch_req && !i_cache_hit) begin
                    miss_addr_d = i_fetch_addr;
                    cnt_d       = sat_inc(cnt_q);
                    beat_d      = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                o_mem_req = 1'b1;
                if (i_mem_ack) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (i_mem_rvalid) begin
                    buf_d[beat_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = i_mem_rdata;
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                o_cache_we = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_mem_addr    = {miss_addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign o_cache_block = buf_q;
    assign o_miss_count  = cnt_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: a driver issues misses and memory
// responses, a monitor checks every request and cache write against a queue.
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         arstn = 1'b0;
    logic         fetch_req = 1'b0;
    logic [63:0]  fetch_addr = '0;
    logic         cache_hit;
    logic         mem_ack = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [63:0]  mem_rdata = '0;

    logic [63:0]  cache_addr, mem_addr, s_cache_addr, s_mem_addr;
    logic         cache_we, stall, mem_req, s_cache_we, s_stall, s_mem_req;
    logic [511:0] cache_block, s_cache_block;
    logic [31:0]  miss_count;
    logic [2:0]   s_miss_count;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    icache_refill_ctrl #(.ADDR_WIDTH(64), .BLOCK_WIDTH(512), .MEM_DATA_WIDTH(64), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .arstn(arstn), .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
        .i_cache_hit(cache_hit), .o_cache_addr(cache_addr), .o_cache_we(cache_we),
        .o_cache_block(cache_block), .o_fetch_stall(stall), .o_mem_req(mem_req),
        .o_mem_addr(mem_addr), .i_mem_ack(mem_ack), .i_mem_rvalid(mem_rvalid),
        .i_mem_rdata(mem_rdata), .o_miss_count(miss_count)
    );

    // Narrow-counter copy, driven identically, so saturation is reachable.
    icache_refill_ctrl #(.ADDR_WIDTH(64), .BLOCK_WIDTH(512), .MEM_DATA_WIDTH(64), .CNT_WIDTH(3)) u_sat (
        .clk(clk), .arstn(arstn), .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
        .i_cache_hit(cache_hit), .o_cache_addr(s_cache_addr), .o_cache_we(s_cache_we),
        .o_cache_block(s_cache_block), .o_fetch_stall(s_stall), .o_mem_req(s_mem_req),
        .o_mem_addr(s_mem_addr), .i_mem_ack(mem_ack), .i_mem_rvalid(mem_rvalid),
        .i_mem_rdata(mem_rdata), .o_miss_count(s_miss_count)
    );

    // Direct-mapped cache tag model; block 0x1000 is resident before any refill.
    logic [49:0] ctag [256];
    bit          cvld [256];

    function automatic bit model_hit(input logic [63:0] a);
        if (cvld[a[13:6]]) return ctag[a[13:6]] == a[63:14];
        return a[63:6] == 58'h40;
    endfunction

    always_comb cache_hit = model_hit(cache_addr);

    always @(posedge clk) begin
        if (cache_we) begin
            ctag[cache_addr[13:6]] <= cache_addr[63:14];
            cvld[cache_addr[13:6]] <= 1'b1;
        end
    end

    typedef struct {
        logic [63:0]  addr;
        logic [511:0] blk;
        logic [31:0]  cnt;
        logic [2:0]   scnt;
        int           stall;
        int           reqc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every request cycle and every cache write is checked against the queue head.
    initial begin : monitor
        int   run, reqc;
        bit   after_we;
        exp_t e;
        run = 0; reqc = 0; after_we = 1'b0;
        forever begin
            @(negedge clk);
            if (after_we) begin
                check("stall_drop_after_write", stall, 0);
                after_we = 1'b0;
            end
            if (stall) run++;
            else begin
                run  = 0;
                reqc = 0;
            end
            if (mem_req) begin
                reqc++;
                if (sb.size() == 0) check("mem_req_unexpected", mem_req, 0);
                else begin
                    check("mem_addr", mem_addr, sb[0].addr & ~64'h3F);
                    check("cache_addr_req", cache_addr, sb[0].addr);
                    check("sat_mem_req", s_mem_req, 1);
                    check("sat_mem_addr", s_mem_addr, sb[0].addr & ~64'h3F);
                end
            end
            if (cache_we) begin
                if (sb.size() == 0) check("we_unexpected", cache_we, 0);
                else begin
                    e = sb.pop_front();
                    check("cache_block", cache_block, e.blk);
                    check("cache_addr_write", cache_addr, e.addr);
                    check("miss_count", miss_count, e.cnt);
                    check("stall_cycles", run, e.stall);
                    check("req_cycles", reqc, e.reqc);
                    check("sat_we", s_cache_we, 1);
                    check("sat_block", s_cache_block, e.blk);
                    check("sat_miss_count", s_miss_count, e.scnt);
                    after_we = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [63:0] beats [8];
    int          gaps  [8];
    int          ack_d;
    bit          drop_req;
    int          n_miss = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stray();
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = {$urandom, $urandom};
    endtask

    // Reference: block = beats in order, aligned request address, stall spans
    // miss cycle + request cycles + fill cycles (beats and gaps) + write cycle.
    task automatic refill(input logic [63:0] addr, input bit abort5);
        exp_t e;
        int   tot_g;
        tot_g = 0;
        for (int k = 0; k < 8; k++) begin
            tot_g += gaps[k];
            e.blk[k*64 +: 64] = beats[k];
        end
        n_miss++;
        e.addr  = addr;
        e.cnt   = 32'(n_miss);
        e.scnt  = (n_miss > 7) ? 3'd7 : 3'(n_miss);
        e.stall = 1 + (ack_d + 1) + (8 + tot_g) + 1;
        e.reqc  = ack_d + 1;
        sb.push_back(e);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        mem_rvalid = 1'b0;
        tick();
        for (int i = 0; i < ack_d; i++) begin
            mem_ack = 1'b0;
            stray();
            tick();
        end
        mem_ack = 1'b1;
        stray();
        tick();
        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                mem_rvalid = 1'b0;
                mem_ack    = 1'($urandom_range(0, 1));
                tick();
            end
            mem_ack    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = beats[k];
            if (drop_req && k == 2) fetch_req = 1'b0;
            tick();
            if (abort5 && k == 5) begin
                arstn      = 1'b0;
                fetch_req  = 1'b0;
                mem_rdata  = beats[6];
                void'(sb.pop_back());
                n_miss = 0;
                @(negedge clk);
                check("abort_miss_count", miss_count, 0);
                check("abort_mem_req", mem_req, 0);
                check("abort_we", cache_we, 0);
                check("abort_stall", stall, 0);
                tick();
                mem_rdata = beats[7];
                tick();
                arstn = 1'b1;
                stray();
                tick();
                stray();
                tick();
                mem_rvalid = 1'b0;
                @(negedge clk);
                check("post_abort_mem_req", mem_req, 0);
                check("post_abort_stall", stall, 0);
                check("post_abort_miss_count", miss_count, 0);
                check("post_abort_sat_count", s_miss_count, 0);
                tick();
                return;
            end
        end
        stray();
        mem_ack = 1'($urandom_range(0, 1));
        tick();
        mem_rvalid = 1'b0;
        mem_ack    = 1'b0;
        tick();
    endtask

    task automatic clear_cfg();
        ack_d    = 0;
        drop_req = 1'b0;
        for (int k = 0; k < 8; k++) gaps[k] = 0;
    endtask

    task automatic random_beats();
        for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
    endtask

    initial begin : driver
        logic [63:0] a;
        logic [63:0] filled [$];
        repeat (3) tick();
        @(negedge clk);
        check("rst_we", cache_we, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_block", cache_block, 0);
        check("rst_miss_count", miss_count, 0);
        check("rst_stall", stall, 0);
        tick();
        arstn = 1'b1;
        tick();

        // Hit on a resident block, with a stray beat in IDLE.
        fetch_req  = 1'b1;
        fetch_addr = 64'h1000;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        check("hit_stall", stall, 0);
        check("hit_mem_req", mem_req, 0);
        check("hit_we", cache_we, 0);
        check("hit_miss_count", miss_count, 0);
        check("hit_cache_addr", cache_addr, 64'h1000);
        tick();
        mem_rvalid = 1'b0;

        // Minimum-penalty miss with known beats.
        clear_cfg();
        for (int k = 0; k < 8; k++) beats[k] = 64'h1111_1111_0000_0000 | 64'(k);
        refill(64'h2044, 1'b0);
        filled.push_back(64'h2044);

        // Delayed ack and one gap after beat 3.
        clear_cfg();
        ack_d    = 3;
        gaps[4]  = 1;
        random_beats();
        refill(64'h0000_0000_0003_0108, 1'b0);
        filled.push_back(64'h0000_0000_0003_0108);

        // Reset after beat 5: no write, counter cleared.
        clear_cfg();
        random_beats();
        refill(64'h0000_0000_0005_5540, 1'b1);

        // Fetch request drops during the fill.
        clear_cfg();
        drop_req = 1'b1;
        ack_d    = 1;
        random_beats();
        refill(64'h0000_0000_0007_7f3c, 1'b0);
        filled.push_back(64'h0000_0000_0007_7f3c);

        // Randomized refills, interleaved with hits on earlier blocks.
        for (int t = 0; t < 20; t++) begin
            if (filled.size() > 0 && $urandom_range(0, 2) == 0) begin
                a = filled[$urandom_range(0, filled.size() - 1)];
                if (model_hit(a)) begin
                    fetch_req  = 1'b1;
                    fetch_addr = a;
                    @(negedge clk);
                    check("rehit_stall", stall, 0);
                    tick();
                end
            end
            do a = {$urandom, $urandom}; while (model_hit(a));
            ack_d    = $urandom_range(0, 4);
            drop_req = 1'($urandom_range(0, 3) == 0);
            for (int k = 0; k < 8; k++)
                gaps[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            random_beats();
            refill(a, 1'b0);
            filled.push_back(a);
        end

        fetch_req = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("final_miss_count", miss_count, 21);
        check("final_sat_count", s_miss_count, 7);
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
